// File: rtl/max_stream_ctrl.sv
// ============================================================================
// Module   : max_stream_ctrl (with max_3var)
// Brief    : Reduces a streamed frame of unsigned samples to its maximum value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WIDTH
`define WIDTH 16
`endif

module max_3var #(
   parameter int WIDTH = `WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   output logic [WIDTH-1:0] max_o
);
   logic [WIDTH-1:0] w_ab;

   assign w_ab  = (a_i > b_i) ? a_i : b_i;
   assign max_o = (w_ab > c_i) ? w_ab : c_i;
endmodule

module max_stream_ctrl #(
   parameter int WIDTH = `WIDTH,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [LEN_W-1:0] out_ops,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] pend_q;
   logic             pend_vld_q;
   logic [LEN_W-1:0] remaining_q;
   logic [LEN_W-1:0] ops_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_max_q;
   logic [LEN_W-1:0] out_ops_q;
   logic             busy_q;

   logic             w_last;
   logic [WIDTH-1:0] w_b_sel;
   logic [WIDTH-1:0] acc_d;
   logic [LEN_W-1:0] ops_d;

   // An unpaired final sample is combined with itself (b = c = x).
   assign w_last  = (remaining_q == {{(LEN_W-1){1'b0}}, 1'b1});
   assign w_b_sel = pend_vld_q ? pend_q : in_data;
   assign ops_d   = ops_q + 1'b1;

   max_3var #(.WIDTH(WIDTH)) u_max3 (
      .a_i   (acc_q),
      .b_i   (w_b_sel),
      .c_i   (in_data),
      .max_o (acc_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         pend_q      <= '0;
         pend_vld_q  <= 1'b0;
         remaining_q <= '0;
         ops_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_max_q   <= '0;
         out_ops_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  acc_q      <= '0;
                  ops_q      <= '0;
                  pend_vld_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (cfg_len == '0) begin
                     state_q     <= S_OUT;
                     out_valid_q <= 1'b1;
                     out_max_q   <= '0;
                     out_ops_q   <= '0;
                  end else begin
                     remaining_q <= cfg_len;
                     state_q     <= S_LOAD;
                     in_ready_q  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  remaining_q <= remaining_q - 1'b1;
                  if (!pend_vld_q && !w_last) begin
                     pend_q     <= in_data;
                     pend_vld_q <= 1'b1;
                  end else begin
                     acc_q      <= acc_d;
                     ops_q      <= ops_d;
                     pend_vld_q <= 1'b0;
                  end
                  // Result registers load directly so out_valid rises next cycle.
                  if (w_last) begin
                     state_q     <= S_OUT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_max_q   <= acc_d;
                     out_ops_q   <= ops_d;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_max   = out_max_q;
   assign out_ops   = out_ops_q;
   assign busy      = busy_q;
endmodule

`default_nettype wire

// File: tb/tb_max_stream_ctrl.sv
// ============================================================================
// Module   : tb_max_stream_ctrl
// Brief    : Directed and randomised self-checking bench for max_stream_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max_stream_ctrl;
   localparam int WIDTH = 16;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] cfg_len;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_max;
   logic [LEN_W-1:0] out_ops;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   max_stream_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_len   (cfg_len),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_max   (out_max),
      .out_ops   (out_ops),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives at negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [WIDTH-1:0] x);
      bit acc = 1'b0;
      in_data  = x;
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         acc = in_ready;
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_frame(input logic [LEN_W-1:0] len);
      start   = 1'b1;
      cfg_len = len;
      @(negedge clk);
      start   = 1'b0;
      cfg_len = 8'd77;
   endtask

   task automatic finish_frame(input string tag, input logic [WIDTH-1:0] emax,
                               input logic [LEN_W-1:0] eops);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_max"},   {16'd0, out_max},   {16'd0, emax});
      chk({tag, "_ops"},   {24'd0, out_ops},   {24'd0, eops});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_idle"},  {31'd0, busy},      32'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] smp;
      logic [WIDTH-1:0] rmax;
      int               len;

      rst = 1'b1; start = 1'b0; cfg_len = '0; in_data = '0;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_max",   {16'd0, out_max},   32'd0);
      chk("rst_out_ops",   {24'd0, out_ops},   32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);

      // Frame of 4, in_valid held high throughout
      start_frame(8'd4);
      chk("f4_in_ready", {31'd0, in_ready}, 32'd1);
      chk("f4_busy",     {31'd0, busy},     32'd1);
      in_data = 16'd7; in_valid = 1'b1; @(negedge clk);
      in_data = 16'd2; @(negedge clk);
      in_data = 16'd9; @(negedge clk);
      in_data = 16'd3;
      chk("f4_no_early_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("f4_in_ready_off", {31'd0, in_ready}, 32'd0);
      finish_frame("f4", 16'd9, 8'd2);
      chk("f4_hold_max", {16'd0, out_max}, 32'd9);

      // Odd length: last sample combined with itself
      start_frame(8'd3);
      send(16'd11); send(16'd15); send(16'd5);
      finish_frame("f3", 16'd15, 8'd2);

      // Empty frame
      in_valid = 1'b1; in_data = 16'd500;
      start_frame(8'd0);
      chk("f0_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      finish_frame("f0", 16'd0, 8'd0);

      // Gaps on input, stalled output, start ignored during stall
      start_frame(8'd5);
      send(16'd6);
      @(negedge clk);
      send(16'd13);
      @(negedge clk);
      send(16'd13); send(16'd8); send(16'd1);
      for (int i = 0; i < 3; i++) begin
         start   = (i == 1);
         cfg_len = 8'd2;
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_max",   {16'd0, out_max},   32'd13);
         @(negedge clk);
      end
      start = 1'b0;
      finish_frame("f5", 16'd13, 8'd3);
      @(negedge clk);
      chk("f5_start_ignored", {31'd0, busy}, 32'd0);

      // Reset mid-frame, then a clean frame
      start_frame(8'd4);
      send(16'd100); send(16'd200);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy",     {31'd0, busy},     32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_max",      {16'd0, out_max},  32'd0);
      start_frame(8'd2);
      send(16'd4); send(16'd1);
      finish_frame("f2", 16'd4, 8'd1);

      // Random frames with occasional input gaps and output stalls
      for (int f = 0; f < 100; f++) begin
         len  = $urandom_range(1, 20);
         rmax = '0;
         start_frame(len[LEN_W-1:0]);
         for (int s = 0; s < len; s++) begin
            smp = WIDTH'($urandom);
            if (smp > rmax) rmax = smp;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(smp);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         finish_frame("rnd", rmax, LEN_W'((len + 1) / 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
